// File: rtl/window_feeder.sv
// window_feeder
//   Builds fixed-size windows of 2-bit bases from a streamed read and presents
//   them to window_hasher. Bases arrive one per cycle on a valid/ready
//   handshake. A full window is held frozen with ready_for_hashing high until
//   the hasher's done flag rises, then the feeder slides by STRIDE bases.
//
// Handshake: a base transfers on a rising clk edge where base_valid and
//   base_ready are both 1. base_valid may be raised without waiting for
//   base_ready. base_ready depends only on the FSM state (and reset), never on
//   base_valid.
//
// Ports
//   clk                in   clock, all state on rising edge
//   reset              in   asynchronous, active-high reset
//   base_in[1:0]       in   next base of the read
//   base_valid         in   base_in valid this cycle
//   seq_start          in   base_in is the first base of a new read
//   base_ready         out  feeder accepts base_in this cycle
//   window[0:WS-1]     out  current window, [0] is the oldest base
//   ready_for_hashing  out  window complete and stable (level)
//   hashing_is_done    in   hasher done flag, acted on at its 0->1 edge
//   window_count       out  windows issued since reset or last seq_start
//   dbg_state[1:0]     out  FSM state (0 FILL, 1 ISSUE, 2 SLIDE)
module window_feeder #(
   parameter int WINDOW_SIZE = 128,
   parameter int STRIDE      = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       base_in,
   input  logic             base_valid,
   input  logic             seq_start,
   output logic             base_ready,
   output logic [1:0]       window [0:WINDOW_SIZE-1],
   output logic             ready_for_hashing,
   input  logic             hashing_is_done,
   output logic [CNT_W-1:0] window_count,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WINDOW_SIZE + 1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_ISSUE = 2'd1,
      S_SLIDE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_fill_cnt;
   logic [CW-1:0]    w_fill_nxt;
   logic [CW-1:0]    r_stride_cnt;
   logic [CW-1:0]    w_stride_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_done_q;
   logic [1:0]       r_window [0:WINDOW_SIZE-1];

   logic             w_accept;
   logic             w_done_rise;
   logic [CW-1:0]    w_fill_inc;
   logic [CW-1:0]    w_stride_inc;

   // Held low while reset is asserted so no base is offered a handshake then.
   assign base_ready        = (r_state != S_ISSUE) && !reset;
   assign w_accept          = base_valid && base_ready;
   assign w_done_rise       = hashing_is_done && !r_done_q;
   assign w_fill_inc        = r_fill_cnt + CW'(1);
   assign w_stride_inc      = r_stride_cnt + CW'(1);
   assign ready_for_hashing = (r_state == S_ISSUE);
   assign window_count      = r_count;
   assign window            = r_window;
   assign dbg_state         = r_state;

   always_comb begin
      w_state_nxt  = r_state;
      w_fill_nxt   = r_fill_cnt;
      w_stride_nxt = r_stride_cnt;
      w_count_nxt  = r_count;
      case (r_state)
         S_FILL, S_SLIDE: begin
            if (w_accept) begin
               if (seq_start) begin
                  // New read: the seq_start base is the first of a fresh window.
                  w_fill_nxt  = CW'(1);
                  w_count_nxt = '0;
                  w_state_nxt = (WINDOW_SIZE == 1) ? S_ISSUE : S_FILL;
               end else if (r_state == S_FILL) begin
                  w_fill_nxt = w_fill_inc;
                  if (w_fill_inc == CW'(WINDOW_SIZE)) w_state_nxt = S_ISSUE;
               end else begin
                  w_stride_nxt = w_stride_inc;
                  if (w_stride_inc == CW'(STRIDE)) w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (w_done_rise) begin
               w_state_nxt  = S_SLIDE;
               w_stride_nxt = '0;
               if (r_count != {CNT_W{1'b1}}) w_count_nxt = r_count + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_FILL;
         r_fill_cnt   <= '0;
         r_stride_cnt <= '0;
         r_count      <= '0;
         r_done_q     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fill_cnt   <= w_fill_nxt;
         r_stride_cnt <= w_stride_nxt;
         r_count      <= w_count_nxt;
         r_done_q     <= hashing_is_done;
      end
   end

   // Window only moves on an accepted base; ISSUE drops base_ready, so the
   // window is frozen while ready_for_hashing is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WINDOW_SIZE; i++) r_window[i] <= 2'b00;
      end else if (w_accept) begin
         for (int i = 0; i < WINDOW_SIZE - 1; i++) r_window[i] <= r_window[i+1];
         r_window[WINDOW_SIZE-1] <= base_in;
      end
   end

endmodule
